// File: rtl/ls_cnt_multi_if.sv
// Bundle of the compare/readout signals shared between the host side and ls_cnt_multi.
// The host drives the stimulus and readout select; the counter block drives status and readout.
interface ls_cnt_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int SEL_W = 2
);
    logic             EN;
    logic             CLR;
    logic             DATA;
    logic [NCH-1:0]   Q;
    logic [SEL_W-1:0] RD_SEL;
    logic [CNT_W-1:0] RD_CNT;
    logic [NCH-1:0]   ERR_BIT;
    logic [NCH-1:0]   LOCKED;
    logic [NCH-1:0]   SAT;

    modport master (
        output EN, CLR, DATA, Q, RD_SEL,
        input  RD_CNT, ERR_BIT, LOCKED, SAT
    );

    modport slave (
        input  EN, CLR, DATA, Q, RD_SEL,
        output RD_CNT, ERR_BIT, LOCKED, SAT
    );
endinterface

// File: rtl/ls_cnt_multi.sv
// Multi-channel latch/shift-register error counter: each chain locks to its first rising
// edge, is compared bit-by-bit against the delayed DATA stream, and feeds a saturating counter.
module ls_cnt_multi #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int DATA_DLY = 0,
    parameter int SEL_W    = 2
) (
    input logic           CLK,
    input logic           RST,
    ls_cnt_multi_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_SYNC,
        ST_COMPARE
    } state_t;

    logic [NCH-1:0]      q1, qs, qp;
    logic [DATA_DLY+1:0] d_sr;
    logic                dd;
    logic [NCH-1:0]      rise;

    state_t              state_q [NCH];
    state_t              state_d [NCH];

    logic [CNT_W-1:0]    cnt [NCH];
    logic [NCH-1:0]      err_bit;
    logic [NCH-1:0]      sat;
    logic [NCH-1:0]      locked;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    rd_next;

    assign dd   = d_sr[DATA_DLY+1];
    assign rise = qs & ~qp;

    // Input pipeline; DATA gets DATA_DLY+2 flops so dd lines up with qs.
    // NOTE: every clocked process uses non-blocking (<=) so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q1   <= '0;
            qs   <= '0;
            qp   <= '0;
            d_sr <= '0;
        end else begin
            q1   <= bus.Q;
            qs   <= q1;
            qp   <= qs;
            d_sr <= {d_sr[DATA_DLY:0], bus.DATA};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NCH; i++) state_q[i] <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            if (bus.CLR) begin
                state_d[i] = ST_ARM;
            end else if (bus.EN) begin
                case (state_q[i])
                    ST_ARM:     if (rise[i]) state_d[i] = ST_SYNC;
                    ST_SYNC:    if (dd)      state_d[i] = ST_COMPARE;
                    ST_COMPARE: state_d[i] = ST_COMPARE;
                    default:    state_d[i] = ST_ARM;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) locked[i] = (state_q[i] == ST_COMPARE);
    end

    // Compare uses the registered state, so the cycle that enters COMPARE is not compared.
    // NOTE: the counters are a handful of flops, not a RAM, so they take the async reset too.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_bit <= '0;
            sat     <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.CLR) begin
                    err_bit[i] <= 1'b0;
                    sat[i]     <= 1'b0;
                    cnt[i]     <= '0;
                end else begin
                    err_bit[i] <= locked[i] && bus.EN && (qs[i] ^ dd);
                    if (err_bit[i]) begin
                        if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
                        else              sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Out-of-range selects match no channel and read back zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.RD_SEL == SEL_W'(i)) rd_next = cnt[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rd_cnt <= '0;
        else      rd_cnt <= rd_next;
    end

    assign bus.RD_CNT  = rd_cnt;
    assign bus.ERR_BIT = err_bit;
    assign bus.LOCKED  = locked;
    assign bus.SAT     = sat;

endmodule

// File: tb/tb_ls_cnt_multi.sv
// Directed bench for ls_cnt_multi: NCH=4, CNT_W=4, DATA_DLY=2, SEL_W=3 (selects 4..7 out of range).
// Each chain is modelled as DATA delayed two cycles, optionally inverted or flipped for one cycle.
module tb_ls_cnt_multi;

    localparam int NCH      = 4;
    localparam int CNT_W    = 4;
    localparam int DATA_DLY = 2;
    localparam int SEL_W    = 3;

    typedef enum int { M_ZERO, M_FOLLOW, M_INV } mode_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    ls_cnt_multi_if #(.NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    ls_cnt_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .DATA_DLY(DATA_DLY), .SEL_W(SEL_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int             n_checks = 0;
    int             n_errors = 0;
    mode_t          mode [NCH];
    logic [NCH-1:0] flip    = '0;
    logic [NCH-1:0] err_acc = '0;
    logic           d_m1    = 1'b0;
    logic           d_m2    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive DATA and the chain outputs, wait for the edge, return 1 time unit after it.
    task automatic tick(input logic d);
        logic [NCH-1:0] qv;
        qv = '0;
        for (int i = 0; i < NCH; i++) begin
            case (mode[i])
                M_FOLLOW: qv[i] = d_m2 ^ flip[i];
                M_INV:    qv[i] = ~d_m2 ^ flip[i];
                default:  qv[i] = 1'b0;
            endcase
        end
        bus.DATA = d;
        bus.Q    = qv;
        @(posedge CLK);
        #1;
        d_m2    = d_m1;
        d_m1    = d;
        flip    = '0;
        err_acc = err_acc | bus.ERR_BIT;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick(1'($urandom_range(1, 0)));
    endtask

    task automatic prime();
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    endtask

    task automatic set_modes(input mode_t m0, input mode_t m1, input mode_t m2, input mode_t m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    endtask

    initial begin
        bus.EN = 1'b1; bus.CLR = 1'b0; bus.DATA = 1'b0; bus.Q = '0; bus.RD_SEL = '0;
        set_modes(M_FOLLOW, M_FOLLOW, M_FOLLOW, M_FOLLOW);

        // Power-on reset
        @(posedge CLK); @(posedge CLK); #1;
        check("por_locked", 32'(bus.LOCKED),  32'h0);
        check("por_err",    32'(bus.ERR_BIT), 32'h0);
        check("por_sat",    32'(bus.SAT),     32'h0);
        check("por_rdcnt",  32'(bus.RD_CNT),  32'h0);
        RST = 1'b1;

        // Build a nonzero count on ch0, then reset asynchronously mid-cycle
        prime(); run(10);
        check("pre_lock_all", 32'(bus.LOCKED), 32'hF);
        flip[0] = 1'b1; tick(1'b1); run(3);
        flip[0] = 1'b1; tick(1'b0); run(3);
        flip[0] = 1'b1; tick(1'b1); run(6);
        bus.RD_SEL = 3'd0; tick(1'b0);
        check("pre_cnt0", 32'(bus.RD_CNT), 32'd3);
        #2 RST = 1'b0;
        #1;
        check("arst_locked", 32'(bus.LOCKED),  32'h0);
        check("arst_err",    32'(bus.ERR_BIT), 32'h0);
        check("arst_sat",    32'(bus.SAT),     32'h0);
        check("arst_rdcnt",  32'(bus.RD_CNT),  32'h0);
        tick(1'b0); tick(1'b0);
        d_m1 = 1'b0; d_m2 = 1'b0;
        set_modes(M_FOLLOW, M_ZERO, M_ZERO, M_ZERO);
        RST = 1'b1;

        // Lock ch0: rise seen at edge 7, dd=1 at edge 8
        prime();
        tick(1'b0);
        check("lock_e7", 32'(bus.LOCKED), 32'h0);
        tick(1'b1);
        check("lock_e8", 32'(bus.LOCKED), 32'h1);
        err_acc = '0;
        run(1000);
        check("clean_err", 32'(err_acc),    32'h0);
        check("clean_lock", 32'(bus.LOCKED), 32'h1);
        tick(1'b0);
        check("clean_cnt0", 32'(bus.RD_CNT), 32'd0);

        // Single-bit upset on ch2
        set_modes(M_FOLLOW, M_FOLLOW, M_FOLLOW, M_FOLLOW);
        prime(); run(10);
        check("lock_all", 32'(bus.LOCKED), 32'hF);
        flip[2] = 1'b1; tick(1'b1);
        check("seu_k1", 32'(bus.ERR_BIT), 32'h0);
        tick(1'b0);
        check("seu_k2", 32'(bus.ERR_BIT), 32'h0);
        tick(1'b1);
        check("seu_k3", 32'(bus.ERR_BIT), 32'h4);
        bus.RD_SEL = 3'd2; tick(1'b0);
        check("seu_k4_err", 32'(bus.ERR_BIT), 32'h0);
        check("seu_rd_pre", 32'(bus.RD_CNT),  32'd0);
        tick(1'b1);
        check("seu_rd_cnt2", 32'(bus.RD_CNT), 32'd1);

        // Saturation on ch1: 20 mismatching cycles into a 4-bit counter
        check("sat_before", 32'(bus.SAT), 32'h0);
        mode[1] = M_INV; bus.RD_SEL = 3'd1;
        run(10);
        check("sat_mid_cnt", 32'(bus.RD_CNT), 32'd6);
        check("sat_mid_flag", 32'(bus.SAT),   32'h0);
        run(10);
        mode[1] = M_FOLLOW;
        run(5); tick(1'b0);
        check("sat_cnt1", 32'(bus.RD_CNT), 32'd15);
        check("sat_flag", 32'(bus.SAT),    32'h2);
        run(20);
        check("sat_sticky", 32'(bus.SAT),  32'h2);
        check("sat_hold",   32'(bus.RD_CNT), 32'd15);

        // EN gating during a mismatch burst on ch0
        mode[0] = M_INV; bus.RD_SEL = 3'd0;
        run(6);
        check("en_burst_err", 32'(bus.ERR_BIT), 32'h1);
        bus.EN = 1'b0; err_acc = '0;
        run(10);
        mode[0] = M_FOLLOW;
        run(4);
        check("en_off_err", 32'(err_acc), 32'h0);
        tick(1'b0);
        check("en_off_cnt0", 32'(bus.RD_CNT), 32'd4);
        bus.EN = 1'b1;
        run(5);
        check("en_on_cnt0", 32'(bus.RD_CNT), 32'd4);

        // CLR on the edge where ch3 would increment
        mode[3] = M_INV;
        run(5);
        check("clr_err3", 32'(bus.ERR_BIT), 32'h8);
        mode[3] = M_FOLLOW; bus.CLR = 1'b1;
        tick(1'b0);
        check("clr_locked", 32'(bus.LOCKED),  32'h0);
        check("clr_sat",    32'(bus.SAT),     32'h0);
        check("clr_err",    32'(bus.ERR_BIT), 32'h0);
        bus.CLR = 1'b0; bus.EN = 1'b0; bus.RD_SEL = 3'd3;
        tick(1'b1);
        check("clr_cnt3", 32'(bus.RD_CNT), 32'd0);
        prime(); run(8);
        check("arm_en_off", 32'(bus.LOCKED), 32'h0);
        bus.EN = 1'b1;
        prime(); run(8);
        check("relock", 32'(bus.LOCKED), 32'hF);

        // Readout sweep and out-of-range selects
        flip = 4'b0111; tick(1'b0);
        flip = 4'b0110; tick(1'b1);
        flip = 4'b0100; tick(1'b0);
        run(6);
        for (int s = 0; s < 8; s++) begin
            bus.RD_SEL = SEL_W'(s);
            tick(1'($urandom_range(1, 0)));
            check($sformatf("rd_sel%0d", s), 32'(bus.RD_CNT), (s < 3) ? 32'(s + 1) : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ls_cnt_multi.md
Name: ls_cnt_multi

Overview:
- Multi-channel successor to the single-chain latch/shift-register error counter used in the 12nm SEE test FPGA.
- Takes one reference stream DATA, which is driven into all DUT chains, and NCH chain outputs Q.
- Per channel: synchronises to the first rising edge of that chain's output, aligns it with DATA, and counts bit mismatches in a saturating counter.
- Counters are read one at a time through a registered mux for the host readout logic.

Parameters:
- NCH, 4: number of DUT chains/channels.
- CNT_W, 16: per-channel error counter width.
- DATA_DLY, 0: extra DATA delay in cycles to match the chain's shift latency; range 0..15.
- SEL_W, 2: RD_SEL width; must satisfy 2^SEL_W >= NCH.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous reset, active-low. 0 = reset.
- EN  in  1  global compare enable.
- CLR  in  1  synchronous clear of counters, flags and FSMs.
- DATA  in  1  reference bit stream.
- Q  in  NCH  DUT chain outputs, one bit per channel.
- RD_SEL  in  SEL_W  readout channel select.
- RD_CNT  out  CNT_W  registered count of the selected channel.
- ERR_BIT  out  NCH  registered per-cycle mismatch flag per channel.
- LOCKED  out  NCH  channel is in COMPARE state.
- SAT  out  NCH  sticky flag: channel counter has saturated.

Behaviour:
- Reset (RST=0, async):
  - Outputs: ERR_BIT, LOCKED, SAT, RD_CNT and all counters = 0.
  - All FSMs go to ARM; all pipeline flops clear.
  - Reset mid-compare discards the count immediately; no partial update.
- Input pipeline:
  - Q is double-registered: q1, then qs = stage 2.
  - qp is qs delayed one further cycle.
  - DATA passes through DATA_DLY+2 flops to give dd, so it has the same latency as qs.
  - Edge detect: rise[i] = qs[i] & ~qp[i].
- Per-channel FSM (3 states):
  - ARM: wait for rise[i] while EN=1, then go to SYNC.
  - SYNC: wait for dd=1 while EN=1, then go to COMPARE; LOCKED[i] is set on entry.
  - COMPARE: stay until CLR or reset.
  - EN=0 holds the state in every state.
- Compare:
  - In COMPARE with EN=1: ERR_BIT[i] <= qs[i] ^ dd.
  - Otherwise ERR_BIT[i] <= 0.
  - The comparison in the cycle that enters COMPARE uses the next qs/dd sample; the entry cycle itself is not compared.
- Counter:
  - If ERR_BIT[i]=1 and the counter is below all-ones: counter increments by 1.
  - At all-ones: counter holds and SAT[i] <= 1 (sticky).
  - No wrap-around, ever.
- Latency: a mismatch at the pins at edge k gives ERR_BIT at edge k+3 and the counter increment at edge k+4.
- CLR (sync, priority over EN and over a simultaneous increment):
  - Counters, SAT, ERR_BIT and LOCKED go to 0; FSMs go to ARM.
  - The pipeline flops are not cleared.
- Readout:
  - RD_CNT <= cnt[RD_SEL], 1-cycle latency.
  - RD_SEL >= NCH gives RD_CNT = 0.
  - If an increment and a read hit the same edge, RD_CNT shows the pre-increment value.
- Channels are fully independent; only DATA, EN and CLR are shared.

Test Plan:
1. Reset and lock:
   - Stimulus: RST=0 mid-run with nonzero counts, then release.
   - Required: all outputs 0 asynchronously. Then DATA = 0,0,1,1,0,1…, Q[0] = DATA delayed 2 cycles (with DATA_DLY=2), other Q = 0.
   - Required: LOCKED[0]=1 after the first Q[0] rise plus dd=1. ERR_BIT[0] stays 0 and the count stays 0 over 1000 cycles. Channels 1..3 remain unlocked.
2. Single-bit upset:
   - Stimulus: locked channel 2; flip Q[2] for exactly one cycle at edge k.
   - Required: ERR_BIT[2]=1 for only edge k+3; cnt[2]=1. RD_SEL=2 gives RD_CNT=1 one cycle later.
3. Saturation:
   - Stimulus: CNT_W=4; hold Q[1] inverted from DATA for 20 cycles after lock.
   - Required: count stops at 15 with no wrap; SAT[1]=1 and stays high.
4. EN gating:
   - Stimulus: EN=0 for 10 cycles during a burst of mismatches.
   - Required: ERR_BIT=0 and counts frozen during that window. A channel in ARM does not lock on a rise while EN=0.
5. CLR versus increment:
   - Stimulus: assert CLR on the same edge ERR_BIT[3]=1.
   - Required: next cycle cnt[3]=0, SAT[3]=0, LOCKED[3]=0. A new rise on Q[3] relocks the channel.
6. Readout out of range:
   - Stimulus: NCH=3, RD_SEL=3.
   - Required: RD_CNT=0. Sweeping RD_SEL 0..2 returns each channel's count with 1-cycle latency.
